// File: rtl/booth_multiplier_seq_if.sv
// booth_multiplier_seq_if: start/operand request and busy/done/result response bundle
interface booth_multiplier_seq_if #(parameter int WIDTH = 32);
  logic start;
  logic is_signed;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] result;
  modport master(output start, is_signed, in0, in1, input busy, done, result);
  modport slave(input start, is_signed, in0, in1, output busy, done, result);
endinterface

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: iterative radix-2 Booth multiplier, one step per clock
module booth_multiplier_seq #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  booth_multiplier_seq_if.slave bus
);
  localparam int N = WIDTH + 1;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [N-1:0] m, a, q, sum;
  logic q_1;
  logic [CW-1:0] cnt;
  logic [2*N-1:0] prod;
  // one extra operand bit lets the same N-step Booth loop handle unsigned operands
  always_comb begin
    sum = {q[0], q_1} == 2'b01 ? a + m : {q[0], q_1} == 2'b10 ? a - m : a;
    prod = {sum[N-1], sum, q[N-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m <= '0;
      a <= '0;
      q <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.result <= '0;
    end else if (state != RUN) begin
      bus.done <= 1'b0;
      if (bus.start) begin
        state <= RUN;
        bus.busy <= 1'b1;
        m <= {bus.is_signed & bus.in0[WIDTH-1], bus.in0};
        q <= {bus.is_signed & bus.in1[WIDTH-1], bus.in1};
        a <= '0;
        q_1 <= 1'b0;
        cnt <= '0;
      end else begin
        state <= IDLE;
      end
    end else begin
      {a, q, q_1} <= {prod, q[0]};
      cnt <= cnt + 1'b1;
      if (cnt == CW'(N - 1)) begin
        state <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.result <= prod[2*WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb_booth_multiplier_seq: directed and random checks of 4/8/32-bit instances against a product/timing model
module tb_booth_multiplier_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int wid[3] = '{4, 8, 32};
  logic rst[3], start[3], sg[3], busy_o[3], done_o[3];
  logic [31:0] a_in[3], b_in[3];
  logic [63:0] res_o[3];
  int total = 0, bad = 0;
  bit chk_on = 1'b0;
  booth_multiplier_seq_if #(4) if4();
  booth_multiplier_seq_if #(8) if8();
  booth_multiplier_seq_if #(32) if32();
  booth_multiplier_seq #(.WIDTH(4)) u4(.clk(clk), .rst(rst[0]), .bus(if4.slave));
  booth_multiplier_seq #(.WIDTH(8)) u8(.clk(clk), .rst(rst[1]), .bus(if8.slave));
  booth_multiplier_seq #(.WIDTH(32)) u32(.clk(clk), .rst(rst[2]), .bus(if32.slave));
  assign if4.start = start[0];
  assign if4.is_signed = sg[0];
  assign if4.in0 = a_in[0][3:0];
  assign if4.in1 = b_in[0][3:0];
  assign busy_o[0] = if4.busy;
  assign done_o[0] = if4.done;
  assign res_o[0] = 64'(if4.result);
  assign if8.start = start[1];
  assign if8.is_signed = sg[1];
  assign if8.in0 = a_in[1][7:0];
  assign if8.in1 = b_in[1][7:0];
  assign busy_o[1] = if8.busy;
  assign done_o[1] = if8.done;
  assign res_o[1] = 64'(if8.result);
  assign if32.start = start[2];
  assign if32.is_signed = sg[2];
  assign if32.in0 = a_in[2];
  assign if32.in1 = b_in[2];
  assign busy_o[2] = if32.busy;
  assign done_o[2] = if32.done;
  assign res_o[2] = if32.result;

  function automatic logic [63:0] ref_mul(int w, bit s, logic [31:0] x, logic [31:0] y);
    logic [63:0] mk;
    longint sx, sy;
    logic [63:0] p;
    mk = (w == 32) ? 64'hFFFF_FFFF : (64'd1 << w) - 64'd1;
    sx = longint'({32'd0, x} & mk);
    sy = longint'({32'd0, y} & mk);
    if (s && x[w-1]) sx = sx - longint'(64'd1 << w);
    if (s && y[w-1]) sy = sy - longint'(64'd1 << w);
    p = 64'(sx * sy);
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  int m_left[3];
  logic m_busy[3], m_done[3];
  logic [63:0] m_res[3], m_prod[3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        m_left[i] <= 0;
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_res[i] <= '0;
        m_prod[i] <= '0;
      end else if (!m_busy[i] && start[i]) begin
        m_prod[i] <= ref_mul(wid[i], sg[i], a_in[i], b_in[i]);
        m_left[i] <= wid[i] + 1;
        m_busy[i] <= 1'b1;
        m_done[i] <= 1'b0;
      end else if (m_busy[i]) begin
        m_left[i] <= m_left[i] - 1;
        m_done[i] <= m_left[i] == 1;
        m_busy[i] <= m_left[i] != 1;
        if (m_left[i] == 1) m_res[i] <= m_prod[i];
      end else begin
        m_done[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("busy%0d", wid[i]), 64'(busy_o[i]), 64'(m_busy[i]));
        chk($sformatf("done%0d", wid[i]), 64'(done_o[i]), 64'(m_done[i]));
        chk($sformatf("result%0d", wid[i]), res_o[i], m_res[i]);
      end
    end
  end

  task automatic op(int i, bit s, logic [31:0] x, logic [31:0] y, logic [63:0] exp, bit poke);
    int n = 0, bc = 0;
    @(negedge clk);
    start[i] = 1'b1;
    sg[i] = s;
    a_in[i] = x;
    b_in[i] = y;
    do begin
      @(negedge clk);
      n++;
      start[i] = poke && n == 3;
      a_in[i] = $urandom;
      b_in[i] = $urandom;
      sg[i] = ~sg[i];
      if (busy_o[i]) bc++;
    end while (!done_o[i] && n < 200);
    start[i] = 1'b0;
    chk($sformatf("latency%0d", wid[i]), 64'(n), 64'(wid[i] + 2));
    chk($sformatf("busy_cycles%0d", wid[i]), 64'(bc), 64'(wid[i] + 1));
    chk($sformatf("product%0d", wid[i]), res_o[i], exp);
  endtask

  task automatic b2b(int i, bit s, logic [31:0] x1, logic [31:0] y1, logic [31:0] x2, logic [31:0] y2);
    int n = 0;
    @(negedge clk);
    start[i] = 1'b1;
    sg[i] = s;
    a_in[i] = x1;
    b_in[i] = y1;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o[i] && n < 200);
    chk("b2b_first", res_o[i], ref_mul(wid[i], s, x1, y1));
    a_in[i] = x2;
    b_in[i] = y2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("b2b_no_idle", 64'(busy_o[i]), 64'd1);
    end while (!done_o[i] && n < 200);
    start[i] = 1'b0;
    chk("b2b_gap", 64'(n), 64'(wid[i] + 2));
    chk("b2b_second", res_o[i], ref_mul(wid[i], s, x2, y2));
  endtask

  initial begin
    int dc;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      start[i] = 1'b0;
      sg[i] = 1'b0;
      a_in[i] = '0;
      b_in[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_busy", 64'(busy_o[i]), 64'd0);
      chk("reset_done", 64'(done_o[i]), 64'd0);
      chk("reset_result", res_o[i], 64'd0);
      rst[i] = 1'b0;
    end
    chk_on = 1'b1;
    chk("ref_u4", ref_mul(4, 0, 32'd9, 32'd3), 64'h1B);
    chk("ref_s4", ref_mul(4, 1, 32'd9, 32'd3), 64'hEB);
    chk("ref_s32_max", ref_mul(32, 1, 32'h8000_0000, 32'h7FFF_FFFF), 64'hC000_0000_8000_0000);
    chk("ref_u32_ones", ref_mul(32, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    op(0, 0, 32'd9, 32'd3, 64'h1B, 0);
    op(0, 1, 32'd9, 32'd3, 64'hEB, 0);
    op(0, 0, 32'd9, 32'd3, 64'h1B, 1);
    op(0, 1, 32'd8, 32'd8, 64'h40, 0);
    op(1, 1, 32'h80, 32'h7F, 64'hC080, 0);
    op(1, 0, 32'hFF, 32'hFF, 64'hFE01, 1);
    op(2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    op(2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, 0);
    op(2, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    op(2, 1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 1);
    op(2, 1, 32'h1234_5678, 32'h0, 64'h0, 0);
    op(2, 0, 32'h0, 32'hFFFF_FFFF, 64'h0, 0);
    b2b(0, 1, 32'd9, 32'd3, 32'd7, 32'd15);
    b2b(2, 0, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h2);
    @(negedge clk);
    start[2] = 1'b1;
    sg[2] = 1'b1;
    a_in[2] = 32'h7654_3210;
    b_in[2] = 32'h8765_4321;
    @(negedge clk);
    start[2] = 1'b0;
    repeat (9) @(negedge clk);
    rst[2] = 1'b1;
    start[2] = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy_o[2]), 64'd0);
    chk("midrst_done", 64'(done_o[2]), 64'd0);
    chk("midrst_result", res_o[2], 64'd0);
    rst[2] = 1'b0;
    start[2] = 1'b0;
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o[2]) dc++;
    end
    chk("midrst_no_done", 64'(dc), 64'd0);
    op(2, 1, 32'hFFFF_FFFE, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF6, 0);
    for (int k = 0; k < 24; k++) begin
      logic [31:0] x, y;
      bit s;
      x = $urandom;
      y = $urandom;
      s = k[0];
      op(1 + (k % 2 == 0 ? 0 : 1), s, x, y, ref_mul(k % 2 == 0 ? 8 : 32, s, x, y), k % 5 == 0);
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_multiplier_seq.md
# booth_multiplier_seq

Parametrised sequential radix-2 Booth multiplier, the iterative successor of the 4-bit combinational Booth array. It accepts two WIDTH-bit operands on a start pulse and computes their full 2·WIDTH-bit product, one Booth step per clock. It reports completion with a one-cycle done pulse. A per-operation mode bit selects signed (two's complement) or unsigned operands, so one instance serves both integer-multiply flavours in the datapath.

## Interface
- WIDTH, 32, operand width in bits; must be 2 or greater.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- is_signed  input  1  1 = both operands two's complement; 0 = both unsigned; sampled with start.
- in0  input  WIDTH  multiplicand; sampled with start.
- in1  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is iterating.
- done  output  1  one-cycle pulse; result is valid from this cycle onward.
- result  output  2·WIDTH  product; registered and held until the next completion.

## Operation
- FSM states:
  - IDLE: wait for start. start=1 at an edge captures the operands and moves to RUN.
  - RUN: one Booth step per edge. After WIDTH+1 steps, move to DONE.
  - DONE: done=1. An edge with start=1 captures new operands and goes to RUN; otherwise go to IDLE.
- Operand capture: in0 and in1 are extended to N = WIDTH+1 bits.
  - Sign-extended when is_signed=1; zero-extended when is_signed=0.
  - Extended in0 is stored as M; extended in1 is loaded into Q.
  - A (N bits) is cleared to 0, Q₋₁ is cleared to 0, and the step counter is cleared to 0.
- Booth step, selected by {Q[0], Q₋₁}:
  - 01: A = A + M.
  - 10: A = A − M.
  - 00 and 11: A unchanged.
  - Then arithmetic right shift of {A, Q, Q₋₁} by one bit; A[N−1] is replicated into the MSB.
  - All add/subtract arithmetic is modulo 2^N.
- Exactly N steps are performed in both modes.
- The final {A, Q} is 2N bits; result is loaded with its low 2·WIDTH bits on the last RUN edge.
- Operands are registered at capture. Changes on in0, in1 or is_signed after capture do not affect the running operation.
- start during RUN is ignored: no queueing, no restart.
- Reset:
  - Values: state=IDLE, busy=0, done=0, result=0, internal registers=0.
  - Reset mid-RUN aborts the operation. No done pulse is produced for it, and result reads 0.
  - rst has priority over start in the same cycle.

## Timing
- Let edge E0 be the edge at which start is accepted.
- busy=1 from E0 through E(WIDTH+1); it falls at edge E(WIDTH+1).
- Steps execute at edges E1 … E(WIDTH+1).
- result is updated at E(WIDTH+1).
- done=1 for exactly the cycle between E(WIDTH+1) and E(WIDTH+2).
- Latency from accepted start to done: WIDTH+1 cycles (33 cycles at WIDTH=32).
- Back-to-back operation: if start=1 at E(WIDTH+2) (the DONE cycle), the next operation begins with no idle cycle.
  - Throughput is one product per WIDTH+2 cycles.
- busy and done are never high in the same cycle.
- result changes only at a completion edge or on reset.

## Test plan
- WIDTH=4, unsigned, in0=9, in1=3, start for one cycle:
  - busy is high for 5 cycles.
  - done pulses 5 cycles after the start edge.
  - result=8'h1B.
- WIDTH=4, signed, in0=4'b1001 (−7), in1=4'b0011 (3) → result=8'hEB (−21).
  - Same operands with is_signed=0 → 8'h1B (27).
- WIDTH=32 corner products:
  - unsigned 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE00000001.
  - signed 0xFFFFFFFF×0xFFFFFFFF → 0x1.
  - signed 0x80000000×0x80000000 → 0x4000000000000000.
  - signed 0x80000000×0x7FFFFFFF → 0xC000000080000000.
  - any operand ×0 → 0.
- Protocol check:
  - Pulse start again mid-RUN with different operands; it must be ignored, with one done pulse and the original product.
  - Change in0/in1 after capture; result must be unaffected.
  - Hold start high through DONE; the second operation must begin with no idle cycle, and the second done must arrive WIDTH+2 cycles after the first.
- Reset check:
  - Assert rst for one cycle at step 10 of a 32-bit operation.
  - Required: busy=0, done=0 and result=0 the next cycle, and no done pulse follows.
  - A fresh start then completes correctly.
- Randomised signed and unsigned operands at WIDTH=8 and WIDTH=32, compared against a reference multiply: every done must match.
